// File: rtl/contador_tempo.sv
// ---------------------------------------------------------------------------
// contador_tempo
//
// Stopwatch time base and BCD counter. Sits right after the stopwatch state
// machine and turns its estado/contando/enable outputs into six BCD digits
// (MM:SS.CC) for the display decoder.
//
//   - A prescaler divides clk down to a 1 centisecond tick while contando=1.
//   - The tick drives a BCD cascade: cent_u, cent_d, seg_u, seg_d, min_u, min_d.
//   - A separate bank of display registers follows the internal count while
//     enable=1 and freezes while enable=0 (split / lap). Time keeps running
//     underneath a frozen display.
//
// Parameters
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  count rate in Hz (100 -> one tick per centisecond)
//
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous reset, active low
//   estado    in   3  FSM state: 0 inicio, 1 contar, 2 pausar, 3 parar
//   contando  in   1  1 = time advances
//   enable    in   1  1 = display follows internal count, 0 = display frozen
//   cent_u    out  4  BCD centiseconds units (0-9)
//   cent_d    out  4  BCD centiseconds tens  (0-9)
//   seg_u     out  4  BCD seconds units      (0-9)
//   seg_d     out  4  BCD seconds tens       (0-5)
//   min_u     out  4  BCD minutes units      (0-9)
//   min_d     out  4  BCD minutes tens       (0-5)
//   estouro   out  1  one-cycle pulse when the count wraps 59:59.99 -> 00:00.00
// ---------------------------------------------------------------------------
module contador_tempo #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] estado,
  input  logic       contando,
  input  logic       enable,
  output logic [3:0] cent_u,
  output logic [3:0] cent_d,
  output logic [3:0] seg_u,
  output logic [3:0] seg_d,
  output logic [3:0] min_u,
  output logic [3:0] min_d,
  output logic       estouro
);

  // Clock cycles per tick; must be at least 2.
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [3:0] NINE = 4'd9;
  localparam logic [3:0] FIVE = 4'd5;
  localparam logic [3:0] ONE  = 4'd1;

  localparam logic [2:0] ESTADO_INICIO = 3'd0;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             sync_clear;

  // Internal (always running) digits
  logic [3:0] int_cent_u;
  logic [3:0] int_cent_d;
  logic [3:0] int_seg_u;
  logic [3:0] int_seg_d;
  logic [3:0] int_min_u;
  logic [3:0] int_min_d;

  // Next-state of the internal digits
  logic [3:0] nxt_cent_u;
  logic [3:0] nxt_cent_d;
  logic [3:0] nxt_seg_u;
  logic [3:0] nxt_seg_d;
  logic [3:0] nxt_min_u;
  logic [3:0] nxt_min_d;
  logic       wrap_all;

  // Stopped in the initial state means "zero everything"; this wins over
  // counting and over a frozen display.
  assign sync_clear = (estado == ESTADO_INICIO) && !contando;

  // The >= compare makes an out-of-range prescaler value recover on the
  // next tick instead of running through the whole counter width.
  assign tick = contando && (div_cnt >= DIV_LAST);

  // Prescaler. It only moves while contando=1, so the phase of the next
  // tick survives a pause or stop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (sync_clear) begin
      div_cnt <= '0;
    end else if (contando) begin
      if (div_cnt >= DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

  // BCD carry chain. Each digit only moves when every lower digit is at its
  // maximum. The "< limit" tests also push any illegal value back to 0 with
  // a carry, so a digit can never sit outside its BCD range.
  always_comb begin
    nxt_cent_u = int_cent_u;
    nxt_cent_d = int_cent_d;
    nxt_seg_u  = int_seg_u;
    nxt_seg_d  = int_seg_d;
    nxt_min_u  = int_min_u;
    nxt_min_d  = int_min_d;
    wrap_all   = 1'b0;

    if (tick) begin
      if (int_cent_u < NINE) begin
        nxt_cent_u = int_cent_u + ONE;
      end else begin
        nxt_cent_u = '0;
        if (int_cent_d < NINE) begin
          nxt_cent_d = int_cent_d + ONE;
        end else begin
          nxt_cent_d = '0;
          if (int_seg_u < NINE) begin
            nxt_seg_u = int_seg_u + ONE;
          end else begin
            nxt_seg_u = '0;
            if (int_seg_d < FIVE) begin
              nxt_seg_d = int_seg_d + ONE;
            end else begin
              nxt_seg_d = '0;
              if (int_min_u < NINE) begin
                nxt_min_u = int_min_u + ONE;
              end else begin
                nxt_min_u = '0;
                if (int_min_d < FIVE) begin
                  nxt_min_d = int_min_d + ONE;
                end else begin
                  nxt_min_d = '0;
                  wrap_all  = 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

  // Internal count registers plus the overflow pulse. estouro is loaded in
  // the same edge that writes 00:00.00, so it is high exactly for the cycle
  // in which the wrapped value first appears internally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_cent_u <= '0;
      int_cent_d <= '0;
      int_seg_u  <= '0;
      int_seg_d  <= '0;
      int_min_u  <= '0;
      int_min_d  <= '0;
      estouro    <= 1'b0;
    end else if (sync_clear) begin
      int_cent_u <= '0;
      int_cent_d <= '0;
      int_seg_u  <= '0;
      int_seg_d  <= '0;
      int_min_u  <= '0;
      int_min_d  <= '0;
      estouro    <= 1'b0;
    end else begin
      int_cent_u <= nxt_cent_u;
      int_cent_d <= nxt_cent_d;
      int_seg_u  <= nxt_seg_u;
      int_seg_d  <= nxt_seg_d;
      int_min_u  <= nxt_min_u;
      int_min_d  <= nxt_min_d;
      estouro    <= wrap_all;
    end
  end

  // Display registers. They copy the current internal digits (one cycle
  // behind the count) while enable=1 and hold otherwise. Because they load
  // the internal value directly, releasing a split jumps straight to the
  // live time with no intermediate values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cent_u <= '0;
      cent_d <= '0;
      seg_u  <= '0;
      seg_d  <= '0;
      min_u  <= '0;
      min_d  <= '0;
    end else if (sync_clear) begin
      cent_u <= '0;
      cent_d <= '0;
      seg_u  <= '0;
      seg_d  <= '0;
      min_u  <= '0;
      min_d  <= '0;
    end else if (enable) begin
      cent_u <= int_cent_u;
      cent_d <= int_cent_d;
      seg_u  <= int_seg_u;
      seg_d  <= int_seg_d;
      min_u  <= int_min_u;
      min_d  <= int_min_d;
    end
  end

endmodule

// File: tb/tb_contador_tempo.sv
// ---------------------------------------------------------------------------
// tb_contador_tempo
//
// Directed bench for contador_tempo with CLK_HZ=1000, TICK_HZ=100 (DIV=10).
// A small behavioural model keeps the time as an integer number of
// centiseconds plus the prescaler phase. Every stimulus step advances the
// model edge by edge and pushes the expected display value into a
// scoreboard queue; checkOutput pops it and compares with the DUT digits.
// Inputs change and outputs are sampled on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_contador_tempo;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int HOUR_CS = 360000;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic [2:0] estado   = 3'd0;
  logic       contando = 1'b0;
  logic       enable   = 1'b0;

  logic [3:0] cent_u;
  logic [3:0] cent_d;
  logic [3:0] seg_u;
  logic [3:0] seg_d;
  logic [3:0] min_u;
  logic [3:0] min_d;
  logic       estouro;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected display values, packed as {MM,SS,CC} in BCD
  logic [23:0] sb_q[$];

  // Reference model state
  int   m_cs   = 0;
  int   m_div  = 0;
  int   m_disp = 0;
  logic m_est  = 1'b0;

  int est_seen = 0;

  contador_tempo #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .estado  (estado),
    .contando(contando),
    .enable  (enable),
    .cent_u  (cent_u),
    .cent_d  (cent_d),
    .seg_u   (seg_u),
    .seg_d   (seg_d),
    .min_u   (min_u),
    .min_d   (min_d),
    .estouro (estouro)
  );

  always #5 clk = ~clk;

  // Convert a centisecond count into the six packed BCD digits
  function automatic logic [23:0] to_bcd(input int cs);
    int mins;
    int secs;
    int cents;
    mins  = cs / 6000;
    secs  = (cs / 100) % 60;
    cents = cs % 100;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            4'(cents / 10), 4'(cents % 10)};
  endfunction

  // One rising edge of the reference model using the current inputs
  task automatic modelEdge();
    int pre;
    if (estado == 3'd0 && !contando) begin
      m_cs   = 0;
      m_div  = 0;
      m_disp = 0;
      m_est  = 1'b0;
    end else begin
      pre   = m_cs;
      m_est = 1'b0;
      if (contando) begin
        if (m_div == DIV - 1) begin
          m_div = 0;
          m_cs  = (m_cs + 1) % HOUR_CS;
          if (m_cs == 0) m_est = 1'b1;
        end else begin
          m_div = m_div + 1;
        end
      end
      if (enable) m_disp = pre;
    end
  endtask

  // Drive the inputs, run n rising edges, and queue the expected display
  task automatic applyStimulus(input logic [2:0] est, input logic cont,
                               input logic en, input int n);
    estado   = est;
    contando = cont;
    enable   = en;
    for (int i = 0; i < n; i++) begin
      modelEdge();
      @(negedge clk);
      if (estouro) est_seen++;
    end
    sb_q.push_back(to_bcd(m_disp));
  endtask

  task automatic checkOutput(input string tag);
    logic [23:0] obs;
    logic [23:0] exp;
    obs = {min_d, min_u, seg_d, seg_u, cent_d, cent_u};
    exp = sb_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    applyStimulus(3'd0, 1'b0, 1'b0, 0);
    checkOutput("reset_state");
    checkFlag("reset_estouro", estouro, 1'b0);
    reset = 1'b1;

    // Plain run: 1500 edges, display lags by one cycle, then settles on 01.50
    $display("[TB] run 1500 clocks");
    est_seen = 0;
    applyStimulus(3'd1, 1'b1, 1'b1, 1500);
    checkOutput("run_lag");
    applyStimulus(3'd1, 1'b0, 1'b1, 1);
    checkOutput("run_1500");
    checkCount("run_no_estouro", est_seen, 0);

    // Split: freeze at 00:02.00 while time keeps running underneath
    $display("[TB] split");
    applyStimulus(3'd1, 1'b1, 1'b1, 501);
    checkOutput("split_pre");
    applyStimulus(3'd1, 1'b1, 1'b0, 1500);
    checkOutput("split_mid");
    applyStimulus(3'd1, 1'b1, 1'b0, 1500);
    checkOutput("split_end");
    applyStimulus(3'd1, 1'b1, 1'b1, 1);
    checkOutput("split_release");

    // Synchronous clear beats a frozen display; counting restarts from zero
    $display("[TB] sync clear");
    applyStimulus(3'd0, 1'b0, 1'b0, 1);
    checkOutput("sync_clear");
    applyStimulus(3'd1, 1'b1, 1'b1, 10);
    checkOutput("restart_10");
    applyStimulus(3'd1, 1'b1, 1'b1, 1);
    checkOutput("restart_11");

    // Pause with prescaler at phase 5; next tick arrives 5 edges after resume
    $display("[TB] pause keeps tick phase");
    applyStimulus(3'd1, 1'b1, 1'b1, 4);
    checkOutput("pause_pre");
    applyStimulus(3'd2, 1'b0, 1'b1, 500);
    checkOutput("pause_hold");
    applyStimulus(3'd1, 1'b1, 1'b1, 5);
    checkOutput("resume_5");
    applyStimulus(3'd1, 1'b1, 1'b1, 1);
    checkOutput("resume_6");
    applyStimulus(3'd3, 1'b0, 1'b0, 20);
    checkOutput("hold_all");

    // Wrap: preload the internal count to 59:59.90 and run through the wrap
    $display("[TB] wrap");
    force dut.int_min_d  = 4'd5;
    force dut.int_min_u  = 4'd9;
    force dut.int_seg_d  = 4'd5;
    force dut.int_seg_u  = 4'd9;
    force dut.int_cent_d = 4'd9;
    force dut.int_cent_u = 4'd0;
    #1;
    release dut.int_min_d;
    release dut.int_min_u;
    release dut.int_seg_d;
    release dut.int_seg_u;
    release dut.int_cent_d;
    release dut.int_cent_u;
    m_cs = HOUR_CS - 10;
    applyStimulus(3'd3, 1'b0, 1'b1, 1);
    checkOutput("wrap_preload");
    est_seen = 0;
    for (int i = 0; i < 110; i++) begin
      applyStimulus(3'd1, 1'b1, 1'b1, 1);
      checkOutput($sformatf("wrap_disp_%0d", i));
      checkFlag($sformatf("wrap_estouro_%0d", i), estouro, m_est);
    end
    checkCount("wrap_pulses", est_seen, 1);

    // Asynchronous reset between edges
    $display("[TB] async reset");
    applyStimulus(3'd1, 1'b1, 1'b1, 7);
    checkOutput("pre_reset");
    #2;
    reset = 1'b0;
    #1;
    m_cs   = 0;
    m_div  = 0;
    m_disp = 0;
    m_est  = 1'b0;
    applyStimulus(3'd1, 1'b1, 1'b1, 0);
    checkOutput("async_reset");
    checkFlag("async_estouro", estouro, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(3'd1, 1'b1, 1'b1, 11);
    checkOutput("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
